mdu_e: RTL and testbench

Multiply/divide unit in the E stage of the five-stage pipeline, sitting directly downstream of the D-stage controller. It executes mult/multu/div/divu over a fixed multi-cycle latency and holds the architectural HI/LO registers. It services mfhi/mflo/mthi/mtlo and exports a hazard flag that the D-stage controller ORs into its stall so that no MD-class instruction leaves D while the unit is occupied.

---
 rtl/mdu_e.sv | 162 ++++++++++++++++
 tb/tb_mdu_e.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_e.sv
// mdu_e: E-stage multiply/divide unit with architectural HI/LO.
// Fixed-latency mult/div, mfhi/mflo/mthi/mtlo, D-stage hazard flag.
module mdu_e #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic        mdu_hazard,
  output logic [31:0] mdu_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CLG = $clog2(MAXC + 1);
  localparam int unsigned CW  = (CLG > 4) ? CLG : 4;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [31:0]     res_hi, res_hi_n;
  logic [31:0]     res_lo, res_lo_n;
  logic            res_skip, res_skip_n;
  logic [31:0]     hi_n, lo_n;

  logic            is_md;
  logic [63:0]     prod_s, prod_u;
  logic            div_zero, div_ovf;
  logic [31:0]     dsor;
  logic signed [31:0] a_s, b_s;
  logic [31:0]     quo_s, rem_s, quo_u, rem_u;

  assign is_md = (mdu_op >= OP_MULT) && (mdu_op <= OP_DIVU);
  assign busy = (state == RUN);
  assign mdu_hazard = busy | is_md;

  // mfhi/mflo read port, zero for everything else
  always_comb begin
    mdu_out = 32'h0;
    if (mdu_op == OP_MFHI) mdu_out = hi;
    else if (mdu_op == OP_MFLO) mdu_out = lo;
  end

  // Full-width arithmetic; divisor forced to 1 on zero to keep it X-free
  always_comb begin
    prod_s   = $signed({{32{rs_data[31]}}, rs_data})
             * $signed({{32{rt_data[31]}}, rt_data});
    prod_u   = {32'h0, rs_data} * {32'h0, rt_data};
    div_zero = (rt_data == 32'h0);
    div_ovf  = (rs_data == 32'h8000_0000)
            && (rt_data == 32'hFFFF_FFFF);
    dsor     = div_zero ? 32'h1 : rt_data;
    a_s      = $signed(rs_data);
    b_s      = $signed(dsor);
    quo_u    = rs_data / dsor;
    rem_u    = rs_data % dsor;
    if (div_ovf) begin
      quo_s = 32'h8000_0000;
      rem_s = 32'h0;
    end else begin
      quo_s = $unsigned(a_s / b_s);
      rem_s = $unsigned(a_s % b_s);
    end
  end

  // Next-state: start/mthi/mtlo in IDLE, countdown and commit in RUN
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    res_hi_n   = res_hi;
    res_lo_n   = res_lo;
    res_skip_n = res_skip;
    hi_n       = hi;
    lo_n       = lo;
    unique case (state)
      IDLE: begin
        case (mdu_op)
          OP_MULT: begin
            res_hi_n   = prod_s[63:32];
            res_lo_n   = prod_s[31:0];
            res_skip_n = 1'b0;
            cnt_n      = CW'(MULT_CYCLES);
            state_n    = RUN;
          end
          OP_MULTU: begin
            res_hi_n   = prod_u[63:32];
            res_lo_n   = prod_u[31:0];
            res_skip_n = 1'b0;
            cnt_n      = CW'(MULT_CYCLES);
            state_n    = RUN;
          end
          OP_DIV: begin
            res_hi_n   = rem_s;
            res_lo_n   = quo_s;
            res_skip_n = div_zero;
            cnt_n      = CW'(DIV_CYCLES);
            state_n    = RUN;
          end
          OP_DIVU: begin
            res_hi_n   = rem_u;
            res_lo_n   = quo_u;
            res_skip_n = div_zero;
            cnt_n      = CW'(DIV_CYCLES);
            state_n    = RUN;
          end
          OP_MTHI: hi_n = rs_data;
          OP_MTLO: lo_n = rs_data;
          default: ;
        endcase
      end
      RUN: begin
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_n = IDLE;
          if (!res_skip) begin
            hi_n = res_hi;
            lo_n = res_lo;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register; reset aborts any in-flight op without commit
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      res_hi   <= 32'h0;
      res_lo   <= 32'h0;
      res_skip <= 1'b0;
      hi       <= 32'h0;
      lo       <= 32'h0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      res_hi   <= res_hi_n;
      res_lo   <= res_lo_n;
      res_skip <= res_skip_n;
      hi       <= hi_n;
      lo       <= lo_n;
    end
  end

endmodule

// File: tb/tb_mdu_e.sv
// tb_mdu_e: randomized and directed checks of mdu_e against
// a cycle-indexed behavioural model of HI/LO and occupancy.
module tb_mdu_e;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  mdu_op;
  logic [31:0] rs_data, rt_data;
  logic        busy, mdu_hazard;
  logic [31:0] mdu_out, hi, lo;

  mdu_e #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .mdu_op(mdu_op),
    .rs_data(rs_data), .rt_data(rt_data),
    .busy(busy), .mdu_hazard(mdu_hazard),
    .mdu_out(mdu_out), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int n_viol = 0;
  bit chk_en = 1'b0;

  longint m_cyc = 0;
  longint m_free = 0;
  logic [31:0] m_hi = 0, m_lo = 0;
  logic [31:0] p_hi, p_lo;
  bit p_skip = 1'b0;

  function automatic bit m_busy();
    return m_cyc < m_free;
  endfunction

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  // Model of one clock edge, driven from the spec's timing rules
  task automatic model_edge();
    longint a, b;
    int op;
    op = int'(mdu_op);
    if (reset) begin
      m_hi = 0; m_lo = 0; m_free = 0; p_skip = 0;
    end else if (m_busy()) begin
      if (op >= 1 && op <= 8) begin
        n_viol++;
        $display("note: op %0d presented while busy, ignored", op);
      end
      if (m_cyc + 1 == m_free && !p_skip) begin
        m_hi = p_hi; m_lo = p_lo;
      end
    end else begin
      case (op)
        1, 2: begin
          if (op == 1) begin
            a = longint'($signed(rs_data));
            b = longint'($signed(rt_data));
          end else begin
            a = longint'({32'h0, rs_data});
            b = longint'({32'h0, rt_data});
          end
          {p_hi, p_lo} = 64'(a * b);
          p_skip = 0;
          m_free = m_cyc + MC + 1;
        end
        3, 4: begin
          if (op == 3) begin
            a = longint'($signed(rs_data));
            b = longint'($signed(rt_data));
          end else begin
            a = longint'({32'h0, rs_data});
            b = longint'({32'h0, rt_data});
          end
          p_skip = (b == 0);
          if (b != 0) begin
            p_lo = 32'(a / b);
            p_hi = 32'(a % b);
          end
          m_free = m_cyc + DC + 1;
        end
        7: m_hi = rs_data;
        8: m_lo = rs_data;
        default: ;
      endcase
    end
    m_cyc++;
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 64'(busy), 64'(m_busy()));
      check("hazard", 64'(mdu_hazard),
            64'(m_busy() || (mdu_op >= 1 && mdu_op <= 4)));
      check("mdu_out", 64'(mdu_out),
            64'(mdu_op == 5 ? m_hi : mdu_op == 6 ? m_lo : 32'h0));
      check("hi", 64'(hi), 64'(m_hi));
      check("lo", 64'(lo), 64'(m_lo));
    end
  end

  task automatic step(input logic [3:0] op,
                      input logic [31:0] a,
                      input logic [31:0] b,
                      input logic r);
    mdu_op = op; rs_data = a; rt_data = b; reset = r;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(4'd0, 32'h0, 32'h0, 1'b0);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int bc;
    logic [3:0] op;
    logic [31:0] a, b;

    mdu_op = 0; rs_data = 0; rt_data = 0; reset = 1;
    step(4'd0, 32'h0, 32'h0, 1'b1);
    chk_en = 1'b1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);

    step(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    bc = 0;
    repeat (MC + 2) begin
      if (busy) bc++;
      idle(1);
    end
    check("multu_busy_cycles", 64'(bc), 64'd5);
    check("multu_hi", 64'(hi), 64'h1);
    check("multu_lo", 64'(lo), 64'hFFFF_FFFE);
    mdu_op = 4'd5; #1;
    check("mfhi_out", 64'(mdu_out), 64'h1);
    step(4'd5, 32'h0, 32'h0, 1'b0);

    step(4'd1, 32'hFFFF_FFFD, 32'd5, 1'b0);
    idle(2);
    mdu_op = 4'd6; #1;
    check("mflo_during_busy", 64'(mdu_out), 64'hFFFF_FFFE);
    idle(MC - 2);
    check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(lo), 64'hFFFF_FFF1);

    step(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    idle(DC);
    check("div_lo", 64'(lo), 64'hFFFF_FFFD);
    check("div_hi", 64'(hi), 64'hFFFF_FFFF);
    step(4'd4, 32'd7, 32'd2, 1'b0);
    idle(DC);
    check("divu_lo", 64'(lo), 64'd3);
    check("divu_hi", 64'(hi), 64'd1);
    step(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle(DC);
    check("div_ovf_lo", 64'(lo), 64'h8000_0000);
    check("div_ovf_hi", 64'(hi), 64'h0);

    step(4'd7, 32'h1234, 32'h0, 1'b0);
    step(4'd8, 32'h5678, 32'h0, 1'b0);
    check("mthi", 64'(hi), 64'h1234);
    check("mtlo", 64'(lo), 64'h5678);
    step(4'd4, 32'd9, 32'd0, 1'b0);
    bc = 0;
    repeat (DC) begin
      if (busy) bc++;
      idle(1);
    end
    check("div0_busy_cycles", 64'(bc), 64'd10);
    check("div0_hi", 64'(hi), 64'h1234);
    check("div0_lo", 64'(lo), 64'h5678);

    mdu_op = 4'd1; #1;
    check("hazard_start", 64'(mdu_hazard), 64'd1);
    step(4'd1, 32'd6, 32'd7, 1'b0);
    idle(1);
    step(4'd7, 32'hDEAD, 32'h0, 1'b0);
    idle(MC - 2);
    check("ign_hi", 64'(hi), 64'h0);
    check("ign_lo", 64'(lo), 64'd42);
    check("hazard_after", 64'(mdu_hazard), 64'd0);

    step(4'd3, 32'd100, 32'd7, 1'b0);
    idle(3);
    step(4'd0, 32'h0, 32'h0, 1'b1);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    step(4'd2, 32'd3, 32'd3, 1'b0);
    idle(MC);
    check("after_abort_lo", 64'(lo), 64'd9);
    idle(DC);
    check("no_late_commit", 64'(lo), 64'd9);

    step(4'd4, 32'd20, 32'd6, 1'b0);
    idle(DC);
    step(4'd2, 32'd5, 32'd5, 1'b0);
    check("b2b_busy", 64'(busy), 64'd1);
    idle(MC);
    check("b2b_lo", 64'(lo), 64'd25);

    repeat (4000) begin
      if (m_busy())
        op = ($urandom_range(0, 3) == 0)
           ? 4'(9 + $urandom_range(0, 6)) : 4'd0;
      else
        op = 4'($urandom_range(0, 15));
      a = rnd_val();
      b = rnd_val();
      step(op, a, b, ($urandom_range(0, 199) == 0));
    end

    step(4'd0, 32'h0, 32'h0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
